// File: rtl/flopenr_pkg.sv
// Shared constants and helpers for the flopenr elastic register pipeline.
// Optional occupancy counter is enabled with macro FLOPENR_PIPE_OCC_EN.
package flopenr_pkg;

   localparam int FLOPENR_DEF_WIDTH = 8;
   localparam int FLOPENR_DEF_DEPTH = 3;

   // Bits needed to count 0..depth valid stages.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/flopenr_stage.sv
// One elastic slice: enabled data register plus valid bit.
// The slice loads whenever it is empty or its downstream slice drains this cycle.
module flopenr_stage #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             v_in,
   input  logic [WIDTH-1:0] d_in,
   input  logic             rdy_out,
   output logic             v,
   output logic [WIDTH-1:0] d,
   output logic             rdy_in
);

   logic             v_q, v_d;
   logic [WIDTH-1:0] d_q, d_d;

   // Ready ripples backward: an empty slice can always take a beat.
   assign rdy_in = ~v_q | rdy_out;

   // Next state: flush wins, then enabled load; bubbles leave data untouched.
   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (flush) begin
         v_d = 1'b0;
      end else if (rdy_in) begin
         v_d = v_in;
         if (v_in) d_d = d_in;
      end
   end

   // Slice state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v_q <= 1'b0;
         d_q <= RESET_VAL;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign v = v_q;
   assign d = d_q;

endmodule

// File: rtl/flopenr_pipe.sv
// DEPTH-stage elastic pipeline of WIDTH-bit enabled registers with
// valid/ready handshake, pass-through ready chain and synchronous flush.
// Define FLOPENR_PIPE_OCC_EN to add the registered occupancy output occ.
module flopenr_pipe
   import flopenr_pkg::*;
#(
   parameter int               WIDTH     = FLOPENR_DEF_WIDTH,
   parameter int               DEPTH     = FLOPENR_DEF_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef FLOPENR_PIPE_OCC_EN
   ,
   output logic [occ_width(DEPTH)-1:0] occ
`endif
);

   logic [DEPTH:0]                rdy;
   logic [DEPTH-1:0]              v_w;
   logic [DEPTH-1:0][WIDTH-1:0]   d_w;
   logic [DEPTH-1:0]              v_src;
   logic [DEPTH-1:0][WIDTH-1:0]   d_src;
   logic                          in_xfer;

   // Consumer ready terminates the chain; input side is gated by flush and reset.
   assign rdy[DEPTH] = out_ready;
   assign in_ready   = rdy[0] & ~flush & reset_n;
   assign in_xfer    = in_valid & in_ready;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
         assign v_src[gi] = in_xfer;
         assign d_src[gi] = in_data;
      end else begin : g_body
         assign v_src[gi] = v_w[gi-1];
         assign d_src[gi] = d_w[gi-1];
      end

      flopenr_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk     (clk),
         .reset_n (reset_n),
         .flush   (flush),
         .v_in    (v_src[gi]),
         .d_in    (d_src[gi]),
         .rdy_out (rdy[gi+1]),
         .v       (v_w[gi]),
         .d       (d_w[gi]),
         .rdy_in  (rdy[gi])
      );
   end

   assign out_valid = v_w[DEPTH-1];
   assign out_data  = d_w[DEPTH-1];

`ifdef FLOPENR_PIPE_OCC_EN
   localparam int OW = occ_width(DEPTH);

   logic [OW-1:0] occ_q, occ_d;
   logic          out_xfer;

   assign out_xfer = out_valid & out_ready;

   // Occupancy tracks transfers; simultaneous in/out leaves it unchanged.
   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else begin
         case ({in_xfer, out_xfer})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   // Occupancy register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) occ_q <= '0;
      else          occ_q <= occ_d;
   end

   assign occ = occ_q;
`endif

endmodule

// File: tb/tb_flopenr_pipe.sv
// Directed table-driven bench for flopenr_pipe (WIDTH=8, DEPTH=3).
module tb_flopenr_pipe;
   import flopenr_pkg::*;

   localparam int W = 8;
   localparam int D = 3;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_ready, out_valid;
   logic [W-1:0] out_data;
`ifdef FLOPENR_PIPE_OCC_EN
   logic [occ_width(D)-1:0] occ;
`endif

   flopenr_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(8'h00)) dut (
`ifdef FLOPENR_PIPE_OCC_EN
      .occ       (occ),
`endif
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int occ_m = 0;

   typedef struct {
      logic       iv;
      logic [7:0] id;
      logic       ordy;
      logic       fl;
      logic       e_ir;
      logic       e_ov;
      logic [7:0] e_od;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                               input logic fl, input logic e_ir, input logic e_ov,
                               input logic [7:0] e_od);
      vec_t t;
      t.iv = iv; t.id = id; t.ordy = ordy; t.fl = fl;
      t.e_ir = e_ir; t.e_ov = e_ov; t.e_od = e_od;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_occ(input string nm, input int exp);
`ifdef FLOPENR_PIPE_OCC_EN
      chk(nm, 32'(occ), 32'(exp));
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //     iv  id    or fl ir ov od
      // streaming
      tbl.push_back(mk(1, 8'h01, 1, 0, 1, 0, 8'h00));
      tbl.push_back(mk(1, 8'h02, 1, 0, 1, 0, 8'h00));
      tbl.push_back(mk(1, 8'h03, 1, 0, 1, 0, 8'h00));
      tbl.push_back(mk(1, 8'h04, 1, 0, 1, 1, 8'h01));
      tbl.push_back(mk(1, 8'h05, 1, 0, 1, 1, 8'h02));
      tbl.push_back(mk(1, 8'h06, 1, 0, 1, 1, 8'h03));
      tbl.push_back(mk(1, 8'h07, 1, 0, 1, 1, 8'h04));
      tbl.push_back(mk(1, 8'h08, 1, 0, 1, 1, 8'h05));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h06));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h07));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h08));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h08));
      // back-pressure
      tbl.push_back(mk(1, 8'hA1, 0, 0, 1, 0, 8'h08));
      tbl.push_back(mk(1, 8'hA2, 0, 0, 1, 0, 8'h08));
      tbl.push_back(mk(1, 8'hA3, 0, 0, 1, 0, 8'h08));
      tbl.push_back(mk(1, 8'hA4, 0, 0, 0, 1, 8'hA1));
      tbl.push_back(mk(1, 8'hA4, 0, 0, 0, 1, 8'hA1));
      tbl.push_back(mk(1, 8'hA4, 1, 0, 1, 1, 8'hA1));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA2));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA3));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA4));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'hA4));
      // bubble / hold with out_ready toggling
      tbl.push_back(mk(1, 8'h55, 1, 0, 1, 0, 8'hA4));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'hA4));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'hA4));
      tbl.push_back(mk(1, 8'h66, 0, 0, 1, 1, 8'h55));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h55));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h55));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h66));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h66));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h66));
      // flush while full, then recovery
      tbl.push_back(mk(1, 8'h10, 0, 0, 1, 0, 8'h66));
      tbl.push_back(mk(1, 8'h20, 0, 0, 1, 0, 8'h66));
      tbl.push_back(mk(1, 8'h30, 0, 0, 1, 0, 8'h66));
      tbl.push_back(mk(1, 8'h40, 0, 1, 0, 1, 8'h10));
      tbl.push_back(mk(1, 8'h50, 1, 0, 1, 0, 8'h10));
      tbl.push_back(mk(1, 8'h60, 1, 0, 1, 0, 8'h10));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h10));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h50));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h60));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h60));
      // flush while empty blocks the input beat
      tbl.push_back(mk(1, 8'h77, 1, 1, 0, 0, 8'h60));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h60));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h60));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h60));

      // reset held with a live input beat
      reset_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_data", 32'(out_data), 32'h00);
      chk("rst in_ready", 32'(in_ready), 32'd0);
      chk_occ("rst occ", 0);
      in_valid = 1'b0; in_data = 8'h00;
      reset_n = 1'b1;
      #1;
      chk("post-rst in_ready", 32'(in_ready), 32'd1);

      // table
      foreach (tbl[i]) begin
         @(negedge clk);
         in_valid  = tbl[i].iv;
         in_data   = tbl[i].id;
         out_ready = tbl[i].ordy;
         flush     = tbl[i].fl;
         #1;
         chk($sformatf("row%0d in_ready", i),  32'(in_ready),  32'(tbl[i].e_ir));
         chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("row%0d out_data", i),  32'(out_data),  32'(tbl[i].e_od));
         chk_occ($sformatf("row%0d occ", i), occ_m);
         if (tbl[i].fl) occ_m = 0;
         else occ_m = occ_m + int'(tbl[i].iv & tbl[i].e_ir) - int'(tbl[i].e_ov & tbl[i].ordy);
      end

      // async reset with two beats in flight
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b1; in_data = 8'h88; out_ready = 1'b0;
      @(negedge clk);
      in_data = 8'h99;
      @(negedge clk);
      in_valid = 1'b0; in_data = 8'h00;
      @(negedge clk); #1;
      chk("inflight out_valid", 32'(out_valid), 32'd1);
      chk("inflight out_data", 32'(out_data), 32'h88);
      chk_occ("inflight occ", 2);
      #2 reset_n = 1'b0;
      #1;
      chk("async rst out_valid", 32'(out_valid), 32'd0);
      chk("async rst out_data", 32'(out_data), 32'h00);
      chk("async rst in_ready", 32'(in_ready), 32'd0);
      chk_occ("async rst occ", 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("after async rst in_ready", 32'(in_ready), 32'd1);
      chk("after async rst out_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_data = 8'h00;
      @(negedge clk);
      @(negedge clk); #1;
      chk("recover out_valid", 32'(out_valid), 32'd1);
      chk("recover out_data", 32'(out_data), 32'hAA);
      chk_occ("recover occ", 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
